uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_if.sv | 26 ++
 rtl/uart_tx_fifo.sv | 78 +++++++
 tb/tb_uart_tx_fifo.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the byte producer, the FIFO and the UART transmitter.
// slave is the FIFO side; master is the side driving writes and tx_busy.
interface uart_tx_fifo_if #(
    parameter int LOG2_DEPTH = 4
);
    logic [7:0]          wr_data;
    logic                wr_en;
    logic                full;
    logic                empty;
    logic [LOG2_DEPTH:0] count;
    logic                overflow;
    logic [7:0]          tx_data;
    logic                tx_ok;
    logic                tx_busy;
    logic                idle;

    modport slave (
        input  wr_data, wr_en, tx_busy,
        output full, empty, count, overflow, tx_data, tx_ok, idle
    );

    modport master (
        output wr_data, wr_en, tx_busy,
        input  full, empty, count, overflow, tx_data, tx_ok, idle
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter over its data/ok/busy handshake.
// count excludes the byte already presented on tx_data.
module uart_tx_fifo #(
    parameter int LOG2_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [7:0]            r_mem [DEPTH];
    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_DEPTH-1:0] r_rd_ptr;
    logic [LOG2_DEPTH:0]   r_count;
    logic [7:0]            r_tx_data;
    logic                  r_tx_ok;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_launch;

    assign w_full   = (r_count == (LOG2_DEPTH+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = bus.wr_en && !w_full;
    // tx_busy rises only a cycle after the transmitter sees tx_ok, so !r_tx_ok blocks a double launch.
    assign w_launch = !w_empty && !bus.tx_busy && !r_tx_ok;

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.wr_data;
    end

    // Pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_launch) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: push and launch in the same cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     r_count <= '0;
        else if (w_push && !w_launch)  r_count <= r_count + 1'b1;
        else if (!w_push && w_launch)  r_count <= r_count - 1'b1;
    end

    // Registered transmitter strobe and data; tx_data holds between launches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_ok   <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_tx_ok <= w_launch;
            if (w_launch) r_tx_data <= r_mem[r_rd_ptr];
        end
    end

    // One-cycle pulse for each write dropped while full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_overflow <= 1'b0;
        else       r_overflow <= bus.wr_en && w_full;
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_ok    = r_tx_ok;
    assign bus.idle     = w_empty && !r_tx_ok && !bus.tx_busy;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at DEPTH = 4 with a behavioural transmitter model and byte scoreboard.
module tb_uart_tx_fifo;
    localparam int LOG2_DEPTH = 2;
    localparam int DEPTH      = 1 << LOG2_DEPTH;
    localparam int FRAME      = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy_m    = 1'b0;
    logic hold_busy = 1'b0;
    int   frame_cnt = 0;

    int errors = 0;
    int checks = 0;

    // reference model state
    int        m_cnt = 0;
    logic      m_ok  = 1'b0;
    logic      m_ovf = 1'b0;
    logic [7:0] q[$];
    int        n_ok   = 0;
    int        n_push = 0;
    int        n_ovf  = 0;

    uart_tx_fifo_if #(.LOG2_DEPTH(LOG2_DEPTH)) bus();

    uart_tx_fifo #(.LOG2_DEPTH(LOG2_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.tx_busy = busy_m | hold_busy;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    logic m_push, m_launch;
    assign m_push   = bus.wr_en && (m_cnt != DEPTH);
    assign m_launch = (m_cnt != 0) && !bus.tx_busy && !m_ok;

    // Transmitter: latches a byte on tx_ok while idle, busy for FRAME cycles from the next edge.
    always @(posedge clk) begin
        if (busy_m) begin
            if (frame_cnt == 1) busy_m <= 1'b0;
            frame_cnt <= frame_cnt - 1;
        end else if (bus.tx_ok) begin
            busy_m    <= 1'b1;
            frame_cnt <= FRAME;
        end
    end

    // Reference model and scoreboard.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt <= 0;
            m_ok  <= 1'b0;
            m_ovf <= 1'b0;
            q.delete();
        end else begin
            if (m_push) begin
                q.push_back(bus.wr_data);
                n_push <= n_push + 1;
            end
            if (bus.tx_ok && !bus.tx_busy) begin
                n_ok <= n_ok + 1;
                if (q.size() == 0) chk("tx_extra", 32'(bus.tx_data), 32'hxx);
                else               chk("tx_data", 32'(bus.tx_data), 32'(q.pop_front()));
            end
            m_cnt <= m_cnt + (m_push ? 1 : 0) - (m_launch ? 1 : 0);
            m_ok  <= m_launch;
            m_ovf <= bus.wr_en && (m_cnt == DEPTH);
        end
    end

    // Cycle-level compare of every status output away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("count",    32'(bus.count),    32'(m_cnt));
            chk("tx_ok",    32'(bus.tx_ok),    32'(m_ok));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("full",     32'(bus.full),     32'(m_cnt == DEPTH));
            chk("empty",    32'(bus.empty),    32'(m_cnt == 0));
            chk("idle",     32'(bus.idle),     32'((m_cnt == 0) && !m_ok && !bus.tx_busy));
            if (bus.tx_ok) chk("ok_while_busy", 32'(bus.tx_busy), 32'd0);
            if (bus.overflow) n_ovf = n_ovf + 1;
        end
    end

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
    endtask

    task automatic stop_push();
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0 && m_cnt == 0 && !m_ok && !bus.tx_busy) done = 1'b1;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int base;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;

        // reset state, before any clock edge
        #1;
        chk("rst_full",  32'(bus.full),    32'd0);
        chk("rst_empty", 32'(bus.empty),   32'd1);
        chk("rst_count", 32'(bus.count),   32'd0);
        chk("rst_tx_ok", 32'(bus.tx_ok),   32'd0);
        chk("rst_idle",  32'(bus.idle),    32'd1);
        chk("rst_data",  32'(bus.tx_data), 32'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // single byte: push at edge 0, launch at edge 1
        base = n_ok;
        push_byte(8'hA5);
        stop_push();
        chk("single_cnt1",  32'(bus.count), 32'd1);
        chk("single_ok0",   32'(bus.tx_ok), 32'd0);
        @(negedge clk);
        chk("single_ok1",   32'(bus.tx_ok),   32'd1);
        chk("single_data",  32'(bus.tx_data), 32'hA5);
        chk("single_cnt0",  32'(bus.count),   32'd0);
        drain("single_drain");
        chk("single_npulse", 32'(n_ok - base), 32'd1);

        // burst of four in consecutive cycles
        base = n_ok;
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        stop_push();
        drain("burst_drain");
        chk("burst_npulse", 32'(n_ok - base), 32'd4);
        chk("burst_idle",   32'(bus.idle),    32'd1);

        // overflow with the transmitter held busy
        @(negedge clk);
        hold_busy = 1'b1;
        base = n_ovf;
        for (int i = 0; i < 5; i++) begin
            push_byte(8'h10 + 8'(i));
            if (i == 4) chk("ovf_full_after4", 32'(bus.full), 32'd1);
        end
        stop_push();
        repeat (2) @(negedge clk);
        chk("ovf_count",  32'(bus.count),     32'd4);
        chk("ovf_pulses", 32'(n_ovf - base),  32'd1);
        base = n_ok;
        hold_busy = 1'b0;
        drain("ovf_drain");
        chk("ovf_emerged", 32'(n_ok - base), 32'd4);

        // wrap with random writes and concurrent launches
        base = n_push;
        for (int c = 0; c < 3000 && (n_push - base) < 3 * DEPTH; c++) begin
            @(negedge clk);
            bus.wr_en   = ($urandom_range(0, 2) == 0);
            bus.wr_data = 8'($urandom);
        end
        chk("rand_accepted", 32'((n_push - base) >= 3 * DEPTH), 32'd1);
        stop_push();
        drain("rand_drain");

        // reset mid-stream with three queued bytes
        @(negedge clk);
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
        stop_push();
        chk("mid_cnt3", 32'(bus.count), 32'd3);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_ok",    32'(bus.tx_ok), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        reset = 1'b0;
        hold_busy = 1'b0;
        base = n_ok;
        repeat (20) @(negedge clk);
        chk("mid_no_ok", 32'(n_ok - base), 32'd0);
        push_byte(8'h5A);
        stop_push();
        drain("mid_drain");
        chk("mid_new_ok", 32'(n_ok - base), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
